// File: rtl/thrmon_pkg.sv
// Shared types and constants for the threshold monitor: FSM state encoding and event-counter width.
package thrmon_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HIGH      = 2'd2,
    ST_DISARMING = 2'd3
  } thrmon_state_e;

  localparam int unsigned EVENT_CNT_W = 16;

endpackage

// File: rtl/threshold_monitor_comparator.sv
// Unsigned magnitude comparator producing mutually exclusive greater/equal/less flags.
module threshold_monitor_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_a_greater_b,
  output logic             o_a_equal_b,
  output logic             o_a_less_b
);

  always_comb begin
    o_a_greater_b = (i_a > i_b);
    o_a_equal_b   = (i_a == i_b);
    o_a_less_b    = (i_a < i_b);
  end

endmodule

// File: rtl/threshold_monitor.sv
// Debounced hysteresis threshold alarm with rise/fall pulses and peak tracking.
// Optional THRMON_EVENT_COUNT_EN adds a saturating count of rise events on event_count.
module threshold_monitor
  import thrmon_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] threshold,
  input  logic             clear,
  output logic             alarm,
  output logic             rise_pulse,
  output logic             fall_pulse,
`ifdef THRMON_EVENT_COUNT_EN
  output logic [EVENT_CNT_W-1:0] event_count,
`endif
  output logic [WIDTH-1:0] peak
);

  localparam logic [CNT_W-1:0] DEB_TGT = CNT_W'(DEBOUNCE);
  localparam bit               DEB_ONE = (DEBOUNCE == 1);

  thrmon_state_e    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_alarm, r_rise, r_fall;
  logic             w_rise_nxt, w_fall_nxt;
  logic [WIDTH-1:0] r_peak, w_peak_nxt;

  logic w_gt, w_eq, w_lt;
  logic w_pk_gt, w_pk_eq, w_pk_lt;
  logic w_unused;

  threshold_monitor_comparator #(.WIDTH(WIDTH)) u_cmp_thr (
    .i_a           (in_data),
    .i_b           (threshold),
    .o_a_greater_b (w_gt),
    .o_a_equal_b   (w_eq),
    .o_a_less_b    (w_lt)
  );

  threshold_monitor_comparator #(.WIDTH(WIDTH)) u_cmp_peak (
    .i_a           (in_data),
    .i_b           (r_peak),
    .o_a_greater_b (w_pk_gt),
    .o_a_equal_b   (w_pk_eq),
    .o_a_less_b    (w_pk_lt)
  );

  assign w_unused  = ^{w_pk_eq, w_pk_lt, w_eq};
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state: equality falls through every case untouched, forming the hysteresis band.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_peak_nxt  = r_peak;
    if (clear) begin
      w_state_nxt = ST_LOW;
      w_cnt_nxt   = '0;
      w_peak_nxt  = '0;
    end else if (in_valid) begin
      if (w_pk_gt) w_peak_nxt = in_data;
      case (r_state)
        ST_LOW: begin
          if (w_gt) begin
            if (DEB_ONE) begin
              w_state_nxt = ST_HIGH;
              w_cnt_nxt   = '0;
              w_rise_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_ARMING;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_ARMING: begin
          if (w_gt) begin
            if (w_cnt_inc == DEB_TGT) begin
              w_state_nxt = ST_HIGH;
              w_cnt_nxt   = '0;
              w_rise_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else if (w_lt) begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
          end
        end
        ST_HIGH: begin
          if (w_lt) begin
            if (DEB_ONE) begin
              w_state_nxt = ST_LOW;
              w_cnt_nxt   = '0;
              w_fall_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_DISARMING;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_DISARMING: begin
          if (w_lt) begin
            if (w_cnt_inc == DEB_TGT) begin
              w_state_nxt = ST_LOW;
              w_cnt_nxt   = '0;
              w_fall_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else if (w_gt) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_alarm <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_peak  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_alarm <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_DISARMING);
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_peak  <= w_peak_nxt;
    end
  end

  assign alarm      = r_alarm;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign peak       = r_peak;

`ifdef THRMON_EVENT_COUNT_EN
  logic [EVENT_CNT_W-1:0] r_event_cnt, w_event_cnt_nxt;

  // Saturating rise counter; holds at all-ones instead of wrapping.
  always_comb begin
    w_event_cnt_nxt = r_event_cnt;
    if (clear) begin
      w_event_cnt_nxt = '0;
    end else if (w_rise_nxt && (r_event_cnt != {EVENT_CNT_W{1'b1}})) begin
      w_event_cnt_nxt = r_event_cnt + EVENT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_event_cnt <= '0;
    else        r_event_cnt <= w_event_cnt_nxt;
  end

  assign event_count = r_event_cnt;
`endif

endmodule
